// File: rtl/hash_tbl_pkg.sv
// Shared types for the hash-table lookup block: entry layout, FSM states,
// default case-fold mask and a saturating counter helper.
package hash_tbl_pkg;
  localparam int DEF_KEY_W  = 64;
  localparam int DEF_RULE_W = 16;
  localparam logic [DEF_KEY_W-1:0] DEF_ANDMSK = 64'hdfdfdfdfdfdfdfdf;

  typedef struct packed {
    logic                  vld;
    logic [DEF_KEY_W-1:0]  key;
    logic [DEF_RULE_W-1:0] rule;
  } entry_t;

  typedef enum logic {ST_IDLE = 1'b0, ST_CLEAR = 1'b1} fsm_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && v != 32'hFFFFFFFF) ? v + 32'd1 : v;
  endfunction
endpackage

// File: rtl/hash_tbl_ram.sv
// Simple dual-port table RAM: one write port, one registered read port with
// enable. Read-during-write to the same address returns the old contents.
module hash_tbl_ram #(
  parameter int AW = 15,
  parameter int DW = 81
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);
  logic [DW-1:0] r_mem [0:(1<<AW)-1];

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) o_rdata <= r_mem[i_raddr];
  end
endmodule

// File: rtl/hash_table_lookup.sv
// Hash-table lookup: 3-stage ce-gated pipeline over a sync RAM, with write
// bypass/snoop so results see every write up to the output-load edge.
module hash_table_lookup
  import hash_tbl_pkg::*;
#(
  parameter int              NBITS  = 15,
  parameter int              KEY_W  = DEF_KEY_W,
  parameter int              RULE_W = DEF_RULE_W,
  parameter logic [KEY_W-1:0] ANDMSK = DEF_ANDMSK
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ce,
  input  logic [NBITS-1:0]  in_hash,
  input  logic [KEY_W-1:0]  in_key,
  input  logic              in_v,
  input  logic              wr_en,
  input  logic [NBITS-1:0]  wr_addr,
  input  logic [KEY_W-1:0]  wr_key,
  input  logic [RULE_W-1:0] wr_rule,
  input  logic              wr_vld,
  output logic              wr_ready,
  input  logic              clr_req,
  output logic              clr_busy,
  output logic              out_v,
  output logic              out_match,
  output logic [RULE_W-1:0] out_rule,
  output logic [NBITS-1:0]  out_hash,
  output logic [31:0]       lookup_cnt,
  output logic [31:0]       hit_cnt
);
  localparam int DW = 1 + KEY_W + RULE_W;
  localparam logic [NBITS-1:0] LAST = '1;

  typedef struct packed {
    logic              vld;
    logic [KEY_W-1:0]  key;
    logic [RULE_W-1:0] rule;
  } ent_t;

  fsm_t             r_state;
  logic [NBITS-1:0] r_clr_addr;
  logic             w_we;
  logic [NBITS-1:0] w_waddr;
  ent_t             w_wdata;

  logic             r1_v, r1_byp;
  logic [NBITS-1:0] r1_hash;
  logic [KEY_W-1:0] r1_key;
  ent_t             r1_byp_d;
  logic             r2_v;
  logic [NBITS-1:0] r2_hash;
  logic [KEY_W-1:0] r2_key;
  ent_t             r2_ent;
  logic [DW-1:0]    w_rdata;
  ent_t             w_s1_ent, w_s1_snoop, w_s2_ent;
  logic             w_hit;
  logic [31:0]      r_lookup_cnt, r_hit_cnt;

  assign clr_busy   = (r_state == ST_CLEAR);
  assign wr_ready   = (r_state == ST_IDLE);
  assign lookup_cnt = r_lookup_cnt;
  assign hit_cnt    = r_hit_cnt;

  // The clear walk owns the write port; user writes only land in IDLE.
  always_comb begin
    w_we    = 1'b0;
    w_waddr = wr_addr;
    w_wdata = '0;
    if (r_state == ST_CLEAR) begin
      w_we    = 1'b1;
      w_waddr = r_clr_addr;
    end else if (wr_en) begin
      w_we         = 1'b1;
      w_wdata.vld  = wr_vld;
      w_wdata.key  = wr_key & ANDMSK;
      w_wdata.rule = wr_rule;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_CLEAR;
      r_clr_addr <= '0;
    end else begin
      case (r_state)
        ST_CLEAR: begin
          r_clr_addr <= r_clr_addr + NBITS'(1);
          if (r_clr_addr == LAST) r_state <= ST_IDLE;
        end
        default: if (clr_req) begin
          r_state    <= ST_CLEAR;
          r_clr_addr <= '0;
        end
      endcase
    end
  end

  hash_tbl_ram #(.AW(NBITS), .DW(DW)) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_waddr),
    .i_wdata (w_wdata),
    .i_re    (ce),
    .i_raddr (in_hash),
    .o_rdata (w_rdata)
  );

  // Each stage's view of its entry: captured data overridden by a write on this edge.
  assign w_s1_ent   = r1_byp ? r1_byp_d : ent_t'(w_rdata);
  assign w_s1_snoop = (w_we && w_waddr == r1_hash) ? w_wdata : w_s1_ent;
  assign w_s2_ent   = (w_we && w_waddr == r2_hash) ? w_wdata : r2_ent;
  assign w_hit      = r2_v && w_s2_ent.vld && (w_s2_ent.key == r2_key);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_v     <= 1'b0;
      r1_hash  <= '0;
      r1_key   <= '0;
      r1_byp   <= 1'b0;
      r1_byp_d <= '0;
      r2_v     <= 1'b0;
      r2_hash  <= '0;
      r2_key   <= '0;
      r2_ent   <= '0;
    end else if (ce) begin
      r1_v     <= in_v;
      r1_hash  <= in_hash;
      r1_key   <= in_key & ANDMSK;
      r1_byp   <= w_we && (w_waddr == in_hash);
      r1_byp_d <= w_wdata;
      r2_v     <= r1_v;
      r2_hash  <= r1_hash;
      r2_key   <= r1_key;
      r2_ent   <= w_s1_snoop;
    end else begin
      if (w_we && w_waddr == r1_hash) begin
        r1_byp   <= 1'b1;
        r1_byp_d <= w_wdata;
      end
      r2_ent <= w_s2_ent;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_v        <= 1'b0;
      out_match    <= 1'b0;
      out_rule     <= '0;
      out_hash     <= '0;
      r_lookup_cnt <= '0;
      r_hit_cnt    <= '0;
    end else if (ce) begin
      out_v        <= r2_v;
      out_match    <= w_hit;
      out_rule     <= w_hit ? w_s2_ent.rule : '0;
      out_hash     <= r2_hash;
      r_lookup_cnt <= sat_inc(r_lookup_cnt, r2_v);
      r_hit_cnt    <= sat_inc(r_hit_cnt, w_hit);
    end
  end
endmodule

// File: tb/tb_hash_table_lookup.sv
// Scoreboard bench for hash_table_lookup: a table/queue model predicts each
// result at its output edge; a monitor pops and compares when out_v appears.
module tb_hash_table_lookup;
  import hash_tbl_pkg::*;
  localparam int NB = 4;
  localparam int DEPTH = 1 << NB;
  localparam logic [63:0] MSK  = 64'hdfdfdfdfdfdfdfdf;
  localparam logic [63:0] CASE = 64'h2020202020202020;

  logic clk = 0, rst_n = 0, ce = 1;
  logic [NB-1:0] in_hash = '0;
  logic [63:0]   in_key = '0;
  logic          in_v = 0, wr_en = 0, wr_vld = 0, clr_req = 0;
  logic [NB-1:0] wr_addr = '0;
  logic [63:0]   wr_key = '0;
  logic [15:0]   wr_rule = '0;
  logic          wr_ready, clr_busy, out_v, out_match;
  logic [15:0]   out_rule;
  logic [NB-1:0] out_hash;
  logic [31:0]   lookup_cnt, hit_cnt;

  hash_table_lookup #(.NBITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .ce(ce), .in_hash(in_hash), .in_key(in_key), .in_v(in_v),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_rule(wr_rule), .wr_vld(wr_vld),
    .wr_ready(wr_ready), .clr_req(clr_req), .clr_busy(clr_busy), .out_v(out_v),
    .out_match(out_match), .out_rule(out_rule), .out_hash(out_hash),
    .lookup_cnt(lookup_cnt), .hit_cnt(hit_cnt));

  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: table contents, clear-walk progress, pending lookups.
  typedef struct { int left; logic [NB-1:0] hash; logic [63:0] key; } pend_t;
  typedef struct { logic match; logic [15:0] rule; logic [NB-1:0] hash; } exp_t;
  entry_t      tbl [DEPTH];
  int          clr_left;
  pend_t       pend[$];
  exp_t        expq[$];
  logic [31:0] m_lcnt, m_hcnt;

  task automatic model_reset();
    clr_left = DEPTH;
    pend.delete();
    expq.delete();
    m_lcnt = 0;
    m_hcnt = 0;
  endtask

  task automatic model_edge();
    entry_t e;
    exp_t   x;
    pend_t  p;
    if (clr_left != 0) begin
      tbl[DEPTH - clr_left] = '0;
      clr_left--;
    end else begin
      if (wr_en) begin
        e.vld = wr_vld; e.key = wr_key & MSK; e.rule = wr_rule;
        tbl[wr_addr] = e;
      end
      if (clr_req) clr_left = DEPTH;
    end
    if (ce) begin
      for (int i = 0; i < pend.size(); i++) pend[i].left--;
      if (pend.size() > 0 && pend[0].left == 0) begin
        p = pend.pop_front();
        e = tbl[p.hash];
        x.match = e.vld && (e.key == p.key);
        x.rule  = x.match ? e.rule : 16'h0;
        x.hash  = p.hash;
        if (m_lcnt != 32'hFFFFFFFF) m_lcnt++;
        if (x.match && m_hcnt != 32'hFFFFFFFF) m_hcnt++;
        expq.push_back(x);
      end
      if (in_v) begin
        p.left = 2; p.hash = in_hash; p.key = in_key & MSK;
        pend.push_back(p);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) tbl[i] = '0;
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_edge();
    end
  end

  // Monitor: new result on every ce edge, held outputs otherwise.
  initial begin
    logic pv, pm, ce_s;
    logic [15:0] pr;
    logic [NB-1:0] ph;
    exp_t x;
    pv = 0; pm = 0; pr = 0; ph = 0;
    forever begin
      @(posedge clk);
      ce_s = ce;
      #1;
      chk("clr_busy", clr_busy, clr_left != 0);
      chk("wr_ready", wr_ready, clr_left == 0);
      chk("lookup_cnt", lookup_cnt, m_lcnt);
      chk("hit_cnt", hit_cnt, m_hcnt);
      if (!rst_n) begin
        chk("rst_out", {out_v, out_match, out_rule, out_hash}, '0);
      end else if (ce_s) begin
        if (expq.size() > 0) begin
          x = expq.pop_front();
          chk("out_v", out_v, 1'b1);
          chk("out_match", out_match, x.match);
          chk("out_rule", out_rule, x.rule);
          chk("out_hash", out_hash, x.hash);
        end else begin
          chk("out_v_idle", out_v, 1'b0);
        end
      end else begin
        chk("hold", {out_v, out_match, out_rule, out_hash}, {pv, pm, pr, ph});
      end
      pv = out_v; pm = out_match; pr = out_rule; ph = out_hash;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [63:0] keys [4];

  function automatic logic [63:0] rnd_key();
    return keys[$urandom_range(0, 3)] ^ ({$urandom, $urandom} & CASE);
  endfunction

  task automatic step();
    @(negedge clk);
    in_v = 0; wr_en = 0; clr_req = 0;
  endtask

  task automatic do_write(input logic [NB-1:0] a, input logic [63:0] k,
                          input logic [15:0] r, input logic v);
    wr_en = 1; wr_addr = a; wr_key = k; wr_rule = r; wr_vld = v;
    step();
  endtask

  task automatic do_look(input logic [NB-1:0] h, input logic [63:0] k);
    in_v = 1; in_hash = h; in_key = k;
    step();
  endtask

  task automatic drain();
    ce = 1;
    repeat (5) step();
  endtask

  // Counts edges from now until the clear walk finishes.
  task automatic clear_len(input string name, input int look_at);
    int n = 0;
    do begin
      if (n == look_at) begin in_v = 1; in_hash = 3; in_key = rnd_key(); end
      step();
      n++;
    end while (clr_busy && n < 100);
    chk(name, n, DEPTH);
  endtask

  initial begin
    keys[0] = "ABCDEFGH"; keys[1] = "RULEZERO";
    keys[2] = "HASHKEYS"; keys[3] = "TABLE_42";
    // reset state and first clear walk, with a lookup of hash 3 mid-walk
    repeat (3) @(negedge clk);
    chk("rst_busy", {clr_busy, wr_ready}, 2'b10);
    chk("rst_cnts", {lookup_cnt, hit_cnt}, 64'h0);
    rst_n = 1;
    clear_len("clear_len_boot", 5);
    drain();

    // basic hit with exact 3-edge latency, then a one-char miss
    do_write(5, "ABCDEFGH", 16'h0042, 1);
    in_v = 1; in_hash = 5; in_key = "abcdefgh";
    step();
    @(posedge clk); @(posedge clk); #1;
    chk("lat_hit", {out_v, out_match, out_rule}, {1'b1, 1'b1, 16'h0042});
    @(negedge clk);
    do_look(5, "abcdefgX");
    drain();

    // same-edge write+lookup, then delete right after the result
    wr_en = 1; wr_addr = 7; wr_key = keys[2]; wr_rule = 9; wr_vld = 1;
    in_v = 1; in_hash = 7; in_key = keys[2] ^ CASE;
    step(); step(); step();
    do_write(7, keys[2], 16'd9, 0);
    drain();

    // rewrite while the lookup is held in stage 1 / stage 2 by ce=0
    for (int d = 1; d <= 2; d++) begin
      do_write(2, keys[1], 16'd3, 1);
      do_look(2, keys[1] ^ CASE);
      if (d == 2) step();
      ce = 0;
      do_write(2, keys[1], 16'd8, 1);
      repeat (4) step();
      drain();
    end

    // clear with live entries; writes and lookups during the walk
    do_write(1, keys[0], 16'd11, 1);
    do_write(4, keys[1], 16'd12, 1);
    do_write(9, keys[2], 16'd13, 1);
    do_write(12, keys[3], 16'd14, 1);
    clr_req = 1;
    step();
    for (int i = 0; i < 20; i++) begin
      wr_en = 1; wr_addr = 4'(i); wr_key = keys[i % 4]; wr_rule = 16'(i); wr_vld = 1;
      in_v = 1; in_hash = 4'(i); in_key = keys[i % 4];
      step();
    end
    foreach (keys[i]) do_look(4'(1 + 3 * i + (i == 3 ? 0 : 0)), keys[i]);
    do_look(12, keys[3]);
    drain();

    // reset in the middle of a clear walk with lookups in flight
    do_write(3, keys[0], 16'd21, 1);
    do_look(3, keys[0]);
    clr_req = 1;
    step();
    do_look(3, keys[0]);
    repeat (4) step();
    rst_n = 0;
    #1;
    chk("midrst_cnts", {lookup_cnt, hit_cnt}, 64'h0);
    chk("midrst_busy", clr_busy, 1'b1);
    @(negedge clk);
    rst_n = 1;
    clear_len("clear_len_rst", -1);
    drain();

    // hit counter saturation
    do_write(6, keys[3], 16'd5, 1);
    drain();
    force dut.r_hit_cnt = 32'hFFFFFFFE;
    m_hcnt = 32'hFFFFFFFE;
    @(negedge clk);
    release dut.r_hit_cnt;
    for (int i = 0; i < 3; i++) do_look(6, keys[3] ^ CASE);
    drain();
    chk("hit_sat", hit_cnt, 32'hFFFFFFFF);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      ce      = ($urandom_range(0, 7) != 0);
      in_v    = $urandom_range(0, 1);
      in_hash = 4'($urandom_range(0, DEPTH - 1));
      in_key  = rnd_key();
      wr_en   = ($urandom_range(0, 2) == 0);
      wr_addr = 4'($urandom_range(0, DEPTH - 1));
      wr_key  = rnd_key();
      wr_rule = 16'($urandom);
      wr_vld  = ($urandom_range(0, 4) != 0);
      clr_req = ($urandom_range(0, 199) == 0);
      @(negedge clk);
    end
    in_v = 0; wr_en = 0; clr_req = 0;
    drain();
    chk("sb_empty", expq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
